// File: rtl/pool_tree.sv
// pool_tree: pipelined max/average pooling over N_IN samples with LOG2N registered reduction stages.
// Average pooling is compiled in only when POOL_AVG_EN is defined; otherwise every window is max pooled.
module pool_tree #(
  parameter int DATA_WIDTH = 32,
  parameter int N_IN       = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       valid_in,
  output logic                       in_ready,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic                       mode,
  output logic [DATA_WIDTH-1:0]      out,
  output logic                       valid_out,
  input  logic                       out_ready,
  output logic [15:0]                out_count
);
  localparam int LOG2N = $clog2(N_IN);

  logic                  stall_s;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [15:0]           out_count_q, out_count_d;

`ifndef POOL_AVG_EN
  logic mode_unused_s;
  assign mode_unused_s = mode;
`endif

  assign stall_s   = valid_out_q & ~out_ready;
  assign in_ready  = ~stall_s;
  assign out       = out_q;
  assign valid_out = valid_out_q;
  assign out_count = out_count_q;

  for (genvar s = 0; s < LOG2N; s++) begin : g_st
    localparam int NO  = N_IN >> (s + 1);
    localparam int SWI = DATA_WIDTH + s;

    logic                  vl_i;
    logic [DATA_WIDTH-1:0] mx_i [2*NO];
    logic [DATA_WIDTH-1:0] mx_d [NO];
`ifdef POOL_AVG_EN
    logic                  md_i;
    logic [SWI-1:0]        sm_i [2*NO];
    logic [SWI:0]          sm_d [NO];
`endif

    if (s == 0) begin : g_src
      always_comb begin
        vl_i = valid_in;
        for (int k = 0; k < 2*NO; k++) begin
          mx_i[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
`ifdef POOL_AVG_EN
        md_i = mode;
        for (int k = 0; k < 2*NO; k++) begin
          sm_i[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
`endif
      end
    end else begin : g_src
      always_comb begin
        vl_i = g_st[s-1].g_reg.vl_q;
        for (int k = 0; k < 2*NO; k++) begin
          mx_i[k] = g_st[s-1].g_reg.mx_q[k];
        end
`ifdef POOL_AVG_EN
        md_i = g_st[s-1].g_reg.md_q;
        for (int k = 0; k < 2*NO; k++) begin
          sm_i[k] = g_st[s-1].g_reg.sm_q[k];
        end
`endif
      end
    end

    // Tree nodes: signed max with ties to the lower-index operand, and a sign-extended pairwise sum.
    always_comb begin
      for (int j = 0; j < NO; j++) begin
        if ($signed(mx_i[2*j+1]) > $signed(mx_i[2*j])) begin
          mx_d[j] = mx_i[2*j+1];
        end else begin
          mx_d[j] = mx_i[2*j];
        end
`ifdef POOL_AVG_EN
        sm_d[j] = {sm_i[2*j][SWI-1], sm_i[2*j]} + {sm_i[2*j+1][SWI-1], sm_i[2*j+1]};
`endif
      end
    end

    if (s < LOG2N - 1) begin : g_reg
      logic                  vl_q;
      logic [DATA_WIDTH-1:0] mx_q [NO];
`ifdef POOL_AVG_EN
      logic                  md_q;
      logic [SWI:0]          sm_q [NO];
`endif
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          vl_q <= 1'b0;
          for (int j = 0; j < NO; j++) begin
            mx_q[j] <= {DATA_WIDTH{1'b0}};
          end
`ifdef POOL_AVG_EN
          md_q <= 1'b0;
          for (int j = 0; j < NO; j++) begin
            sm_q[j] <= {(SWI+1){1'b0}};
          end
`endif
        end else if (!stall_s) begin
          vl_q <= vl_i;
          for (int j = 0; j < NO; j++) begin
            mx_q[j] <= mx_d[j];
          end
`ifdef POOL_AVG_EN
          md_q <= md_i;
          for (int j = 0; j < NO; j++) begin
            sm_q[j] <= sm_d[j];
          end
`endif
        end
      end
    end else begin : g_out
      // The last node writes straight into the output register, and only for a valid slot so
      // that out keeps the most recent real result through bubbles.
      always_comb begin
        valid_out_d = valid_out_q;
        out_d       = out_q;
        if (!stall_s) begin
          valid_out_d = vl_i;
          if (vl_i) begin
`ifdef POOL_AVG_EN
            if (md_i) begin
              out_d = DATA_WIDTH'($signed(sm_d[0]) >>> LOG2N);
            end else begin
              out_d = mx_d[0];
            end
`else
            out_d = mx_d[0];
`endif
          end else begin
            out_d = out_q;
          end
        end else begin
          valid_out_d = valid_out_q;
        end
      end
    end
  end

  always_comb begin
    if (valid_out_q && out_ready) begin
      out_count_d = out_count_q + 16'd1;
    end else begin
      out_count_d = out_count_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_out_q <= 1'b0;
      out_q       <= {DATA_WIDTH{1'b0}};
      out_count_q <= 16'd0;
    end else begin
      valid_out_q <= valid_out_d;
      out_q       <= out_d;
      out_count_q <= out_count_d;
    end
  end
endmodule

// File: tb/tb_pool_tree.sv
// tb_pool_tree: directed checks of pool_tree at N_IN=4 plus a random sweep at N_IN=2/8/16.
module tb_pool_tree;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic v4, ir4, m4, vo4, r4;
  logic [127:0] d4;
  logic [31:0]  o4;
  logic [15:0]  c4;

  logic rsw;
  logic v2, ir2, m2, vo2;    logic [31:0]  d2;  logic [15:0] o2, c2;
  logic v8, ir8, m8, vo8;    logic [127:0] d8;  logic [15:0] o8, c8;
  logic v16, ir16, m16, vo16; logic [255:0] d16; logic [15:0] o16, c16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pool_tree #(.DATA_WIDTH(32), .N_IN(4)) u4 (
    .clk(clk), .resetn(resetn), .valid_in(v4), .in_ready(ir4), .in_data(d4), .mode(m4),
    .out(o4), .valid_out(vo4), .out_ready(r4), .out_count(c4));
  pool_tree #(.DATA_WIDTH(16), .N_IN(2)) u2 (
    .clk(clk), .resetn(resetn), .valid_in(v2), .in_ready(ir2), .in_data(d2), .mode(m2),
    .out(o2), .valid_out(vo2), .out_ready(rsw), .out_count(c2));
  pool_tree #(.DATA_WIDTH(16), .N_IN(8)) u8 (
    .clk(clk), .resetn(resetn), .valid_in(v8), .in_ready(ir8), .in_data(d8), .mode(m8),
    .out(o8), .valid_out(vo8), .out_ready(rsw), .out_count(c8));
  pool_tree #(.DATA_WIDTH(16), .N_IN(16)) u16 (
    .clk(clk), .resetn(resetn), .valid_in(v16), .in_ready(ir16), .in_data(d16), .mode(m16),
    .out(o16), .valid_out(vo16), .out_ready(rsw), .out_count(c16));

  task automatic tick;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [15:0] ref_pool(input logic [255:0] w, input int n, input logic md);
    logic signed [15:0] mx, smp;
    int sum;
    logic md_unused;
    md_unused = md;
    mx  = w[15:0];
    sum = 0;
    for (int k = 0; k < n; k++) begin
      smp = w[k*16 +: 16];
      if (smp > mx) mx = smp;
      sum += int'(smp);
    end
`ifdef POOL_AVG_EN
    if (md) begin
      sum = sum >>> $clog2(n);
      return sum[15:0];
    end
`endif
    return mx;
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    v4 = 1'b0; m4 = 1'b0; r4 = 1'b1; d4 = 128'd0;
    v2 = 1'b0; v8 = 1'b0; v16 = 1'b0; m2 = 1'b0; m8 = 1'b0; m16 = 1'b0; rsw = 1'b1;
    d2 = 32'd0; d8 = 128'd0; d16 = 256'd0;
    #3;
    checks++;
    if (o4 !== 32'd0 || vo4 !== 1'b0) begin
      errors++; $display("FAIL reset_out got out=%0h vo=%0b exp out=0 vo=0", o4, vo4);
    end
    checks++;
    if (c4 !== 16'd0 || ir4 !== 1'b1) begin
      errors++; $display("FAIL reset_cnt_rdy got cnt=%0d rdy=%0b exp cnt=0 rdy=1", c4, ir4);
    end
    tick; tick;
    resetn = 1'b1;
  endtask

  task automatic test_max_basic;
    d4 = pack4(32'sd3, -32'sd7, 32'sd12, 32'sd5); m4 = 1'b0; v4 = 1'b1;
    tick;
    v4 = 1'b0;
    checks++;
    if (vo4 !== 1'b0) begin errors++; $display("FAIL basic_early got vo=%0b exp 0", vo4); end
    tick;
    checks++;
    if (vo4 !== 1'b1 || o4 !== 32'd12) begin
      errors++; $display("FAIL basic_out got vo=%0b out=%0h exp vo=1 out=c", vo4, o4);
    end
    tick;
    checks++;
    if (vo4 !== 1'b0 || c4 !== 16'd1 || o4 !== 32'd12) begin
      errors++; $display("FAIL basic_after got vo=%0b cnt=%0d out=%0h exp vo=0 cnt=1 out=c", vo4, c4, o4);
    end
  endtask

  task automatic test_tie_sign;
    logic [127:0] w [3];
    logic [31:0]  ex [3];
    w[0] = pack4(-32'sd1, -32'sd1, 32'h8000_0000, -32'sd3);  ex[0] = 32'hFFFF_FFFF;
    w[1] = pack4(-32'sd5, -32'sd9, -32'sd2, -32'sd100);       ex[1] = 32'hFFFF_FFFE;
    w[2] = pack4(32'sd1, 32'sd2, 32'sd3, 32'h7FFF_FFFF);      ex[2] = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      d4 = w[i]; m4 = 1'b0; v4 = 1'b1;
      tick;
      v4 = 1'b0;
      tick;
      checks++;
      if (vo4 !== 1'b1 || o4 !== ex[i]) begin
        errors++; $display("FAIL tie_sign[%0d] got vo=%0b out=%0h exp vo=1 out=%0h", i, vo4, o4, ex[i]);
      end
    end
    tick;
  endtask

  task automatic test_mode_back_to_back;
    logic [127:0] w [5];
    logic         md [5];
    logic [31:0]  ex [5];
    w[0] = pack4(32'sd4, 32'sd5, 32'sd6, 32'sd7);             md[0] = 1'b1;
    w[1] = pack4(-32'sd1, -32'sd2, -32'sd2, -32'sd2);         md[1] = 1'b1;
    w[2] = pack4(32'sd1, 32'sd9, 32'sd2, 32'sd3);             md[2] = 1'b0;
    w[3] = pack4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF); md[3] = 1'b1;
    w[4] = pack4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001); md[4] = 1'b1;
`ifdef POOL_AVG_EN
    ex[0] = 32'd5; ex[1] = 32'hFFFF_FFFE; ex[2] = 32'd9; ex[3] = 32'h7FFF_FFFF; ex[4] = 32'h8000_0000;
`else
    ex[0] = 32'd7; ex[1] = 32'hFFFF_FFFF; ex[2] = 32'd9; ex[3] = 32'h7FFF_FFFF; ex[4] = 32'h8000_0001;
`endif
    for (int i = 0; i < 5; i++) begin
      d4 = w[i]; m4 = md[i]; v4 = 1'b1;
      tick;
      if (i >= 1) begin
        checks++;
        if (vo4 !== 1'b1 || o4 !== ex[i-1]) begin
          errors++; $display("FAIL mode[%0d] got vo=%0b out=%0h exp vo=1 out=%0h", i-1, vo4, o4, ex[i-1]);
        end
      end
    end
    v4 = 1'b0;
    tick;
    checks++;
    if (vo4 !== 1'b1 || o4 !== ex[4]) begin
      errors++; $display("FAIL mode[4] got vo=%0b out=%0h exp vo=1 out=%0h", vo4, o4, ex[4]);
    end
    tick;
    checks++;
    if (vo4 !== 1'b0) begin errors++; $display("FAIL mode_drain got vo=%0b exp 0", vo4); end
  endtask

  task automatic test_backpressure;
    logic [127:0] w [4];
    logic [31:0]  ex [4];
    logic [31:0]  got [$];
    logic [31:0]  held;
    logic [15:0]  c0;
    logic         acc;
    int           idx, st;
    bit           seen;
    w[0] = pack4(32'sd10, 32'sd1, 32'sd2, 32'sd3);   ex[0] = 32'd10;
    w[1] = pack4(32'sd4, 32'sd20, 32'sd5, 32'sd6);   ex[1] = 32'd20;
    w[2] = pack4(32'sd7, 32'sd8, 32'sd30, 32'sd9);   ex[2] = 32'd30;
    w[3] = pack4(32'sd11, 32'sd12, 32'sd13, 32'sd40); ex[3] = 32'd40;
    idx = 0; st = 0; seen = 1'b0; held = 32'd0; c0 = c4; m4 = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      r4 = (st > 0) ? 1'b0 : 1'b1;
      v4 = (idx < 4);
      d4 = w[(idx < 4) ? idx : 0];
      #1;
      if (st > 0) begin
        checks++;
        if (ir4 !== 1'b0 || vo4 !== 1'b1 || o4 !== held) begin
          errors++; $display("FAIL stall_hold got rdy=%0b vo=%0b out=%0h exp rdy=0 vo=1 out=%0h", ir4, vo4, o4, held);
        end
      end
      acc = v4 && ir4;
      if (vo4 && r4) got.push_back(o4);
      tick;
      if (acc) idx++;
      if (st > 0) st--;
      if (vo4 && !seen) begin seen = 1'b1; st = 3; held = o4; end
    end
    v4 = 1'b0; r4 = 1'b1;
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d results exp 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ex[i]) begin
        errors++; $display("FAIL bp_order[%0d] got %0h exp %0h", i, got[i], ex[i]);
      end
    end
    checks++;
    if (c4 - c0 !== 16'd4) begin
      errors++; $display("FAIL bp_out_count got delta %0d exp 4", c4 - c0);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    d4 = pack4(32'sd1, 32'sd2, 32'sd3, 32'sd4); m4 = 1'b0; v4 = 1'b1; r4 = 1'b1;
    tick;
    d4 = pack4(32'sd5, 32'sd6, 32'sd7, 32'sd8);
    tick;
    v4 = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (vo4 !== 1'b0 || o4 !== 32'd0) begin
      errors++; $display("FAIL rst_mid_out got vo=%0b out=%0h exp vo=0 out=0", vo4, o4);
    end
    checks++;
    if (c4 !== 16'd0 || ir4 !== 1'b1) begin
      errors++; $display("FAIL rst_mid_cnt got cnt=%0d rdy=%0b exp cnt=0 rdy=1", c4, ir4);
    end
    tick; tick;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (vo4 !== 1'b0 || o4 !== 32'd0) begin
        errors++; $display("FAIL rst_stale[%0d] got vo=%0b out=%0h exp vo=0 out=0", i, vo4, o4);
      end
    end
    d4 = pack4(-32'sd8, -32'sd3, -32'sd4, -32'sd20); v4 = 1'b1;
    tick;
    v4 = 1'b0;
    tick;
    checks++;
    if (vo4 !== 1'b1 || o4 !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL rst_next got vo=%0b out=%0h exp vo=1 out=fffffffd", vo4, o4);
    end
    tick;
  endtask

  task automatic test_sweep;
    logic [15:0] q2e [$], q8e [$], q16e [$];
    int          q2t [$], q8t [$], q16t [$];
    logic [15:0] e;
    int          t;
    for (int i = 0; i < 30; i++) begin
      v2 = (i < 24); v8 = (i < 24); v16 = (i < 24);
      d2  = $urandom;
      d8  = {$urandom, $urandom, $urandom, $urandom};
      d16 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      m2 = 1'($urandom_range(1)); m8 = 1'($urandom_range(1)); m16 = 1'($urandom_range(1));
      if (v2)  begin q2e.push_back(ref_pool({224'd0, d2}, 2, m2));   q2t.push_back(cyc); end
      if (v8)  begin q8e.push_back(ref_pool({128'd0, d8}, 8, m8));   q8t.push_back(cyc); end
      if (v16) begin q16e.push_back(ref_pool(d16, 16, m16));         q16t.push_back(cyc); end
      tick;
      if (vo2) begin
        checks++;
        if (q2e.size() == 0) begin errors++; $display("FAIL sweep2_extra got %0h exp none", o2); end
        else begin
          e = q2e.pop_front(); t = q2t.pop_front();
          if (o2 !== e || cyc - t != 1) begin
            errors++; $display("FAIL sweep2 got %0h lat %0d exp %0h lat 1", o2, cyc - t, e);
          end
        end
      end
      if (vo8) begin
        checks++;
        if (q8e.size() == 0) begin errors++; $display("FAIL sweep8_extra got %0h exp none", o8); end
        else begin
          e = q8e.pop_front(); t = q8t.pop_front();
          if (o8 !== e || cyc - t != 3) begin
            errors++; $display("FAIL sweep8 got %0h lat %0d exp %0h lat 3", o8, cyc - t, e);
          end
        end
      end
      if (vo16) begin
        checks++;
        if (q16e.size() == 0) begin errors++; $display("FAIL sweep16_extra got %0h exp none", o16); end
        else begin
          e = q16e.pop_front(); t = q16t.pop_front();
          if (o16 !== e || cyc - t != 4) begin
            errors++; $display("FAIL sweep16 got %0h lat %0d exp %0h lat 4", o16, cyc - t, e);
          end
        end
      end
    end
    checks++;
    if (q2e.size() != 0 || q8e.size() != 0 || q16e.size() != 0) begin
      errors++; $display("FAIL sweep_lost got pending %0d/%0d/%0d exp 0/0/0", q2e.size(), q8e.size(), q16e.size());
    end
  endtask

  task automatic test_count_wrap;
    #2;
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    v2 = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      d2 = $urandom;
      tick;
    end
    v2 = 1'b0;
    tick; tick; tick;
    checks++;
    if (c2 !== 16'd65535) begin errors++; $display("FAIL wrap_max got %0d exp 65535", c2); end
    v2 = 1'b1;
    tick;
    v2 = 1'b0;
    tick; tick; tick;
    checks++;
    if (c2 !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", c2); end
  endtask

  initial begin
    test_reset;
    test_max_basic;
    test_tie_sign;
    test_mode_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_sweep;
    test_count_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_tree.md
POOL_TREE -- requirements
Module: pool_tree

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each signed two's-complement sample.
REQ-002 Parameter N_IN, default 4: samples per pooling window; legal values 2, 4, 8, 16. LOG2N = log2(N_IN) is derived and cannot be overridden.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port resetn, input, 1: asynchronous active-low reset.
REQ-005 Port valid_in, input, 1: in_data holds a valid window this cycle.
REQ-006 Port in_ready, output, 1: block accepts a window this cycle.
REQ-007 Port in_data, input, N_IN*DATA_WIDTH: packed window; sample k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port mode, input, 1: 0 = max pooling, 1 = average pooling; sampled together with in_data.
REQ-009 Port out, output, DATA_WIDTH: pooled result.
REQ-010 Port valid_out, output, 1: out holds a valid result.
REQ-011 Port out_ready, input, 1: downstream accepts out this cycle.
REQ-012 Port out_count, output, 16: count of results transferred (valid_out && out_ready).

Function
REQ-013 A window is accepted on a rising edge where valid_in = 1 and in_ready = 1.
REQ-014 Results come from a reduction tree of LOG2N registered stages. Each stage halves the operand count.
REQ-015 Latency is exactly LOG2N cycles from acceptance to valid_out = 1 when out_ready = 1 throughout.
REQ-016 Throughput is one window per cycle when unstalled.
REQ-017 Stall = valid_out && !out_ready. When stall = 1, every stage register, valid bit and mode bit holds its value.
REQ-018 in_ready = !stall, combinational.
REQ-019 out and valid_out hold stable while stalled. Results are never lost or duplicated.
REQ-020 Bubbles (invalid stages) are carried through the pipeline. Collapsing them is not required.
REQ-021 Max mode: each node outputs the larger operand by signed compare. On a tie it outputs the lower-index operand.
REQ-022 Each window carries its own mode bit through the pipeline. A mode change between windows affects only later windows.
REQ-023 Average mode: stage sums are sign-extended, one bit per stage; the final sum is DATA_WIDTH+LOG2N bits.
REQ-024 Average mode: out = final sum arithmetic-shifted right by LOG2N (floor toward negative infinity), truncated to DATA_WIDTH. This cannot overflow.
REQ-025 out_count increments by 1 on each output transfer and wraps from 65535 to 0.
REQ-026 Registers for invalid pipeline slots may hold any value. out must equal the last produced result, or 0 if none since reset.

Reset
REQ-027 resetn = 0 clears all stage registers, valid bits and mode bits immediately, without waiting for clk.
REQ-028 During reset: out = 0, valid_out = 0, out_count = 0, in_ready = 1.
REQ-029 Reset mid-operation discards all in-flight windows. No result from before reset appears afterwards.
REQ-030 The first acceptance can occur on the first rising edge after resetn deasserts.

Configuration
REQ-031 Macro POOL_AVG_EN selects whether average pooling exists.
REQ-032 POOL_AVG_EN defined: average datapath and per-stage mode bits are present, as in REQ-022 to REQ-024.
REQ-033 POOL_AVG_EN undefined:
- mode port still exists but is ignored;
- all windows are max pooled;
- no sum datapath or mode pipeline is synthesized;
- latency and handshake are unchanged.

Verification
REQ-034 N_IN=4, out_ready=1:
- stimulus: window {3, -7, 12, 5}, mode 0, valid_in for 1 cycle;
- required: valid_out = 1 for exactly 1 cycle, 2 cycles later, with out = 12, out_count = 1.
REQ-035 N_IN=4, POOL_AVG_EN defined:
- stimulus: windows {4,5,6,7} then {-1,-2,-2,-2} on back-to-back cycles, mode 1;
- required: out = 5, then out = -2 (sum -7 >>> 2), on consecutive cycles.
REQ-036 Back-pressure:
- stimulus: 4 windows streamed, out_ready = 0 for 3 cycles after the first valid_out;
- required: in_ready = 0 during the stall, out held stable, all 4 results delivered in order with none lost or duplicated.
REQ-037 Tie and signedness:
- stimulus: window {-1, -1, 0x80000000, -3}, mode 0;
- required: out = -1 (0xFFFFFFFF); max tie goes to the lower-index operand.
REQ-038 Reset mid-stream:
- stimulus: resetn pulsed low asynchronously while 2 windows are in flight;
- required: valid_out = 0 and out = 0 immediately, out_count = 0; no stale result after release; the next window produces the correct result.
REQ-039 Parameter sweep: N_IN = 2, 8, 16 with random windows versus a reference model, latency = LOG2N; out_count wraps after 65536 transfers.
